// File: rtl/change_dispenser_if.sv
// Payout handshake bundle for change_dispenser: return request/amount in,
// one-hot hopper coin request and payout status out.
interface change_dispenser_if #(
  parameter int unsigned kNumCoins  = 3,
  parameter int unsigned kTotalBits = 16
);
  logic                  i_return_req;
  logic [kTotalBits-1:0] i_return_amount;
  logic                  i_hopper_ack;
  logic [kNumCoins-1:0]  o_return_coin;
  logic                  o_busy;
  logic                  o_done;
  logic [kTotalBits-1:0] o_shortfall;

  modport master (
    output i_return_req, i_return_amount, i_hopper_ack,
    input  o_return_coin, o_busy, o_done, o_shortfall
  );

  modport slave (
    input  i_return_req, i_return_amount, i_hopper_ack,
    output o_return_coin, o_busy, o_done, o_shortfall
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy largest-coin-first change payout through a hopper handshake, with
// per-denomination inventory. Optional ack timeout: CHANGE_DISPENSER_TIMEOUT_EN.
module change_dispenser #(
  parameter int unsigned kNumCoins   = 3,
  parameter int unsigned kTotalBits  = 16,
  parameter int unsigned INV_BITS    = 8,
  parameter int unsigned INIT_COUNT  = 10,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [kNumCoins-1:0] i_input_coin,
  input  logic [31:0]          coin_value [kNumCoins],
  change_dispenser_if.slave    bus,
  output logic [kNumCoins-1:0] o_inventory_empty
);

  localparam int unsigned kIdxBits = (kNumCoins > 1) ? $clog2(kNumCoins) : 1;
  localparam int unsigned kCmpBits = (kTotalBits > 32) ? kTotalBits : 32;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_DISPENSE, S_DONE} state_t;

  state_t                r_state;
  logic [kTotalBits-1:0] r_remaining;
  logic [INV_BITS-1:0]   r_count [kNumCoins];
  logic [kIdxBits-1:0]   r_coin_idx;
  logic [kNumCoins-1:0]  r_return_coin;
  logic                  r_busy;
  logic                  r_done;
  logic [kTotalBits-1:0] r_shortfall;
  logic [kNumCoins-1:0]  r_empty;

  logic [INV_BITS-1:0]   w_count_nxt [kNumCoins];
  logic                  w_ack_take;
  logic                  w_sel_valid;
  logic [kIdxBits-1:0]   w_sel_idx;

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam int unsigned kTmrBits = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  logic [kTmrBits-1:0]   r_timer;
`endif

  assign bus.o_return_coin = r_return_coin;
  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_shortfall   = r_shortfall;
  assign o_inventory_empty = r_empty;

  assign w_ack_take = (r_state == S_DISPENSE) && bus.i_hopper_ack;

  // Insert and acked dispense of the same coin cancel; inserts saturate.
  always_comb begin
    for (int unsigned i = 0; i < kNumCoins; i++) begin
      w_count_nxt[i] = r_count[i];
      if (i_input_coin[i] && !(w_ack_take && (r_coin_idx == kIdxBits'(i)))) begin
        if (r_count[i] != '1) w_count_nxt[i] = r_count[i] + 1'b1;
      end else if (!i_input_coin[i] && w_ack_take && (r_coin_idx == kIdxBits'(i))) begin
        w_count_nxt[i] = r_count[i] - 1'b1;
      end
    end
  end

  // Ascending scan so the highest fitting denomination wins.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int unsigned i = 0; i < kNumCoins; i++) begin
      if ((r_remaining != '0) && (r_count[i] != '0) &&
          (kCmpBits'(coin_value[i]) <= kCmpBits'(r_remaining))) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = kIdxBits'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_remaining   <= '0;
      r_coin_idx    <= '0;
      r_return_coin <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_shortfall   <= '0;
      for (int unsigned i = 0; i < kNumCoins; i++) begin
        r_count[i] <= INV_BITS'(INIT_COUNT);
        r_empty[i] <= (INIT_COUNT == 0);
      end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
      r_timer       <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < kNumCoins; i++) begin
        r_count[i] <= w_count_nxt[i];
        r_empty[i] <= (w_count_nxt[i] == '0);
      end
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_return_req) begin
            r_remaining <= bus.i_return_amount;
            r_shortfall <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (w_sel_valid) begin
            r_coin_idx    <= w_sel_idx;
            r_return_coin <= kNumCoins'(1) << w_sel_idx;
            r_state       <= S_DISPENSE;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
            r_timer       <= '0;
`endif
          end else begin
            r_done      <= 1'b1;
            r_shortfall <= r_remaining;
            r_state     <= S_DONE;
          end
        end
        S_DISPENSE: begin
          if (bus.i_hopper_ack) begin
            r_remaining   <= r_remaining - kTotalBits'(coin_value[r_coin_idx]);
            r_return_coin <= '0;
            r_state       <= S_SELECT;
          end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
          else if (r_timer == kTmrBits'(ACK_TIMEOUT - 1)) begin
            // Abandoned coin stays in remaining, so it shows up as shortfall.
            r_return_coin <= '0;
            r_done        <= 1'b1;
            r_shortfall   <= r_remaining;
            r_state       <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a greedy
// payout model kept as plain inventory counts.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  i_input_coin = '0;
  logic [31:0] coin_value [3];
  logic [2:0]  o_inventory_empty;

  change_dispenser_if #(.kNumCoins(3), .kTotalBits(16)) bus ();

  change_dispenser #(
    .kNumCoins(3), .kTotalBits(16), .INV_BITS(8), .INIT_COUNT(10), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_input_coin(i_input_coin),
    .coin_value(coin_value), .bus(bus), .o_inventory_empty(o_inventory_empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cv [3] = '{100, 500, 1000};
  int cnt [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int rem);
    int best = -1;
    for (int i = 0; i < 3; i++)
      if (rem > 0 && cv[i] <= rem && cnt[i] > 0) best = i;
    return best;
  endfunction

  function automatic logic [31:0] exp_empty();
    logic [31:0] e = '0;
    for (int i = 0; i < 3; i++) e[i] = (cnt[i] == 0);
    return e;
  endfunction

  function automatic void model_insert(input logic [2:0] ins);
    for (int i = 0; i < 3; i++)
      if (ins[i] && cnt[i] < 255) cnt[i]++;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) cnt[i] = 10;
  endfunction

  // mode: bit0 random latency/inserts, bit1 insert same coin on ack, bit2 extra request while busy
  task automatic payout(input int amount, input int mode);
    int rem, c, lat;
    logic [2:0] oh, ins;
    bit finished = 0;
    rem = amount;
    bus.i_return_amount = 16'(amount);
    bus.i_return_req = 1'b1;
    cycle();
    bus.i_return_req = 1'b0;
    chk("select_busy", {31'b0, bus.o_busy}, 1);
    chk("select_coin", {29'b0, bus.o_return_coin}, 0);
    for (int n = 0; n < 80 && !finished; n++) begin
      c = pick(rem);
      cycle();
      if (c < 0) begin
        chk("done_pulse", {31'b0, bus.o_done}, 1);
        chk("done_shortfall", {16'b0, bus.o_shortfall}, rem);
        chk("done_busy", {31'b0, bus.o_busy}, 1);
        chk("done_coin", {29'b0, bus.o_return_coin}, 0);
        cycle();
        chk("idle_done", {31'b0, bus.o_done}, 0);
        chk("idle_busy", {31'b0, bus.o_busy}, 0);
        chk("idle_shortfall", {16'b0, bus.o_shortfall}, rem);
        chk("idle_empty", {29'b0, o_inventory_empty}, exp_empty());
        finished = 1;
      end else begin
        oh = 3'(1) << c;
        chk("coin_onehot", {29'b0, bus.o_return_coin}, {29'b0, oh});
        lat = (mode & 1) ? int'($urandom_range(0, 2)) : 0;
        for (int w = 0; w < lat; w++) begin
          ins = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
          i_input_coin = ins;
          model_insert(ins);
          if ((mode & 4) && w == 0) begin
            bus.i_return_req = 1'b1;
            bus.i_return_amount = 16'($urandom_range(100, 5000));
          end
          cycle();
          i_input_coin = '0;
          bus.i_return_req = 1'b0;
          chk("coin_hold", {29'b0, bus.o_return_coin}, {29'b0, oh});
        end
        bus.i_hopper_ack = 1'b1;
        ins = (mode & 2) ? oh : 3'b0;
        i_input_coin = ins;
        if ((mode & 4) && lat == 0) begin
          bus.i_return_req = 1'b1;
          bus.i_return_amount = 16'($urandom_range(100, 5000));
        end
        cnt[c]--;
        model_insert(ins);
        rem -= cv[c];
        cycle();
        bus.i_hopper_ack = 1'b0;
        bus.i_return_req = 1'b0;
        i_input_coin = '0;
        chk("ack_clear", {29'b0, bus.o_return_coin}, 0);
        chk("ack_empty", {29'b0, o_inventory_empty}, exp_empty());
      end
    end
    chk("payout_finished", {31'b0, finished}, 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) coin_value[i] = cv[i];
    bus.i_return_req = 1'b0;
    bus.i_return_amount = '0;
    bus.i_hopper_ack = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;
    chk("rst_coin", {29'b0, bus.o_return_coin}, 0);
    chk("rst_busy", {31'b0, bus.o_busy}, 0);
    chk("rst_done", {31'b0, bus.o_done}, 0);
    chk("rst_shortfall", {16'b0, bus.o_shortfall}, 0);
    chk("rst_empty", {29'b0, o_inventory_empty}, 0);

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    bus.i_return_amount = 16'd500;
    bus.i_return_req = 1'b1;
    cycle();
    bus.i_return_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      chk("to_hold", {29'b0, bus.o_return_coin}, 32'd2);
    end
    cycle();
    chk("to_clear", {29'b0, bus.o_return_coin}, 0);
    chk("to_done", {31'b0, bus.o_done}, 1);
    chk("to_shortfall", {16'b0, bus.o_shortfall}, 500);
    cycle();
    chk("to_idle", {31'b0, bus.o_busy}, 0);
`endif

    payout(1600, 0);
    payout(0, 0);
    payout(150, 0);

    // Reset while a coin is being requested.
    bus.i_return_amount = 16'd1000;
    bus.i_return_req = 1'b1;
    cycle();
    bus.i_return_req = 1'b0;
    cycle();
    chk("pre_rst_coin", {29'b0, bus.o_return_coin}, 32'd4);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_coin", {29'b0, bus.o_return_coin}, 0);
    chk("mid_rst_busy", {31'b0, bus.o_busy}, 0);
    chk("mid_rst_shortfall", {16'b0, bus.o_shortfall}, 0);
    chk("mid_rst_empty", {29'b0, o_inventory_empty}, 0);
    cycle();
    reset_n = 1'b1;
    model_reset();

    payout(12000, 0);
    chk("drain_empty", {29'b0, o_inventory_empty}, 32'd4);

    i_input_coin = 3'b100;
    model_insert(3'b100);
    cycle();
    i_input_coin = '0;
    chk("restock_empty", {29'b0, o_inventory_empty}, 0);

    payout(500, 2);
    payout(1600, 4);

    for (int r = 0; r < 25; r++)
      payout(int'($urandom_range(0, 4000)), 1 | (int'($urandom_range(0, 1)) << 1) |
                                             (int'($urandom_range(0, 1)) << 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
